ks_op_8bit: RTL and testbench
=============================

KS_OP_8BIT -- requirements
Module: ks_op_8bit

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; SHALL be a power of two, at least 2.
REQ-002 Parameter: LEVELS, default $clog2(WIDTH) (3 for WIDTH=8), number of Kogge-Stone prefix levels; derived, not overridden.
REQ-003 Port: clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port: rst, input, 1, reset; synchronous and active-high.
REQ-005 Port: a, input, WIDTH, addend A, unsigned.
REQ-006 Port: b, input, WIDTH, addend B, unsigned.
REQ-007 Port: cin, input, 1, carry-in.
REQ-008 Port: sum, output, WIDTH, registered sum bits.
REQ-009 Port: cout, output, 1, registered carry-out from the MSB.

Function
REQ-010 The adder SHALL compute {cout,sum} = a + b + cin over the full WIDTH+1-bit result, with no overflow loss.
REQ-011 The carry network SHALL be a Kogge-Stone parallel prefix: per-bit g=a&b and p=a^b, then LEVELS levels with span 1,2,4,... combining (G,P) pairs.
REQ-012 cin SHALL enter as the level-0 generate of a virtual bit -1, so every carry c[i] = G[i-1:-1].
REQ-013 Each sum bit SHALL be sum[i] = p[i] ^ c[i]; cout SHALL be the group generate over bits WIDTH-1..-1.
REQ-014 Latency SHALL be exactly 1 clock: inputs sampled at edge N appear on sum/cout after edge N; the arithmetic path from a/b/cin to the register input SHALL be purely combinational.
REQ-015 A new operand set SHALL be accepted every cycle (throughput 1/cycle); there is no handshake.
REQ-016 Boundary: all-ones plus cin=1 (full carry propagation) SHALL give sum=0, cout=1 in the same single cycle.
REQ-017 Boundary: X-free inputs SHALL never produce X on outputs after the first post-reset edge.

Reset
REQ-018 When rst=1 at a rising edge, sum SHALL become 0 and cout SHALL become 0, overriding any new inputs.
REQ-019 Reset asserted mid-stream SHALL discard the result of the operand set sampled at that edge; the first valid result SHALL follow the first edge with rst=0.
REQ-020 Before the first reset, output values are undefined; the bench SHALL apply reset first.

Structure
REQ-021 The block SHALL use no shared package; WIDTH and LEVELS are local parameters of the module.
REQ-022 The prefix combining operator (G=Gh|(Ph&Gl), P=Ph&Pl) SHALL be one sub-module, ks_prefix_cell, instantiated by generate loops across levels.
REQ-023 Buffer positions (bit index below the current span) SHALL pass G/P through unchanged; no ripple logic is permitted.

Verification
REQ-024 a=2, b=5, cin=0 -> sum=7, cout=0 one cycle later.
REQ-025 a=20, b=20, cin=1 -> sum=41, cout=0; a=75, b=75, cin=1 -> sum=151, cout=0.
REQ-026 a=128, b=128, cin=0 -> sum=0, cout=1; a=200, b=20, cin=0 -> sum=220, cout=0.
REQ-027 a=255, b=0, cin=1 -> sum=0, cout=1 (full propagate chain); a=255, b=255, cin=1 -> sum=255, cout=1.
REQ-028 Back-to-back vectors each cycle then rst=1 for one edge -> outputs 0/0 at that edge, and the next vector's result appears one cycle after rst deasserts.
REQ-029 A randomized run of at least 10,000 vectors SHALL match a reference a+b+cin model with 1-cycle alignment.

Source files
------------

// File: rtl/ks_prefix_cell.sv
// Kogge-Stone prefix combining cell: merges a high (G,P) group with the adjacent low group.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
//
// Ports:
//   gh, ph : generate/propagate of the more significant group
//   gl, pl : generate/propagate of the less significant, adjacent group
//   g,  p  : combined group generate/propagate
module ks_prefix_cell (
  input  logic gh,
  input  logic ph,
  input  logic gl,
  input  logic pl,
  output logic g,
  output logic p
);

  assign g = gh | (ph & gl);
  assign p = ph & pl;

endmodule

// File: rtl/ks_op_8bit.sv
// Kogge-Stone parallel-prefix adder with registered {cout,sum} = a + b + cin.
// Latency: 1 clock from operand sampling to sum/cout; new operands accepted every cycle.
// Backpressure: none; no handshake, result of every cycle is registered unconditionally.
//
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset, clears sum/cout
//   a, b : unsigned WIDTH-bit addends
//   cin  : carry-in
//   sum  : registered WIDTH-bit sum
//   cout : registered carry-out from the MSB
module ks_op_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int LEVELS = $clog2(WIDTH);
  // Prefix positions: position 0 is the virtual bit -1 carrying cin, position j is bit j-1.
  localparam int NPOS   = WIDTH + 1;

  // gs/ps[l][j]: group (G,P) at position j after l levels. Unpacked per bit so each
  // element has a single driver.
  logic gs [0:LEVELS][0:NPOS-1];
  logic ps [0:LEVELS][0:NPOS-1];

  logic [WIDTH-1:0] p_bit;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_nxt;
  logic             cout_nxt;
  logic             cout_p_unused;

  assign p_bit = a ^ b;

  // Level 0: cin is the generate of the virtual bit, which never propagates.
  assign gs[0][0] = cin;
  assign ps[0][0] = 1'b0;

  generate
    genvar gi, lv, j;

    for (gi = 0; gi < WIDTH; gi++) begin : g_init
      assign gs[0][gi+1] = a[gi] & b[gi];
      assign ps[0][gi+1] = p_bit[gi];
    end

    for (lv = 0; lv < LEVELS; lv++) begin : g_level
      for (j = 0; j < NPOS; j++) begin : g_pos
        if (j >= (1 << lv)) begin : g_cell
          ks_prefix_cell u_cell (
            .gh (gs[lv][j]),
            .ph (ps[lv][j]),
            .gl (gs[lv][j - (1 << lv)]),
            .pl (ps[lv][j - (1 << lv)]),
            .g  (gs[lv+1][j]),
            .p  (ps[lv+1][j])
          );
        end else begin : g_buf
          // Group already reaches the virtual bit; pass through.
          assign gs[lv+1][j] = gs[lv][j];
          assign ps[lv+1][j] = ps[lv][j];
        end
      end
    end

    // After LEVELS levels, positions 0..WIDTH-1 span back to bit -1, so position i
    // holds c[i] = G[i-1:-1].
    for (gi = 0; gi < WIDTH; gi++) begin : g_sum
      assign carry[gi]   = gs[LEVELS][gi];
      assign sum_nxt[gi] = p_bit[gi] ^ carry[gi];
    end
  endgenerate

  // The MSB group spans WIDTH+1 positions, one more than LEVELS levels reach, so
  // fold the top bit's own (g,p) onto c[WIDTH-1] with one more cell.
  ks_prefix_cell u_cout (
    .gh (gs[0][WIDTH]),
    .ph (ps[0][WIDTH]),
    .gl (carry[WIDTH-1]),
    .pl (1'b0),
    .g  (cout_nxt),
    .p  (cout_p_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= sum_nxt;
      cout <= cout_nxt;
    end
  end

endmodule

// File: tb/tb_ks_op_8bit.sv
// Directed and random checks of ks_op_8bit against a + b + cin with one-cycle alignment.
// Latency: expects each result one clock after operands are driven.
// Backpressure: none; operands are driven every cycle.
module tb_ks_op_8bit;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [7:0] sum;
  logic       cout;

  int n_checks = 0;
  int n_fails  = 0;

  ks_op_8bit #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = {cout, sum};
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed cout/sum=%0d/%0d expected %0d/%0d",
             tag, obs[8], obs[7:0], exp[8], exp[7:0]);
    end
  endtask

  // Drive operands, take one edge, then compare 1 time unit after the edge.
  task automatic step(input logic r, input logic [7:0] va, input logic [7:0] vb,
                      input logic vc, input string tag, input logic [8:0] exp);
    rst = r;
    a   = va;
    b   = vb;
    cin = vc;
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] ref_sum;

    rst = 1'b1;
    a   = 8'd0;
    b   = 8'd0;
    cin = 1'b0;

    // Reset overrides live operands.
    @(posedge clk);
    #1;
    step(1'b1, 8'd255, 8'd255, 1'b1, "reset_hold", 9'd0);

    // Directed vectors, back to back.
    step(1'b0, 8'd2,   8'd5,   1'b0, "2+5",        {1'b0, 8'd7});
    step(1'b0, 8'd20,  8'd20,  1'b1, "20+20+1",    {1'b0, 8'd41});
    step(1'b0, 8'd75,  8'd75,  1'b1, "75+75+1",    {1'b0, 8'd151});
    step(1'b0, 8'd128, 8'd128, 1'b0, "128+128",    {1'b1, 8'd0});
    step(1'b0, 8'd200, 8'd20,  1'b0, "200+20",     {1'b0, 8'd220});
    step(1'b0, 8'd255, 8'd0,   1'b1, "255+0+1",    {1'b1, 8'd0});
    step(1'b0, 8'd255, 8'd255, 1'b1, "255+255+1",  {1'b1, 8'd255});
    step(1'b0, 8'd0,   8'd0,   1'b0, "0+0",        {1'b0, 8'd0});
    step(1'b0, 8'd0,   8'd0,   1'b1, "0+0+1",      {1'b0, 8'd1});
    step(1'b0, 8'd85,  8'd170, 1'b0, "85+170",     {1'b0, 8'd255});
    step(1'b0, 8'd85,  8'd170, 1'b1, "85+170+1",   {1'b1, 8'd0});
    step(1'b0, 8'd1,   8'd127, 1'b0, "1+127",      {1'b0, 8'd128});

    // Mid-stream reset discards the operands sampled at that edge.
    step(1'b0, 8'd100, 8'd50,  1'b0, "pre_rst",    {1'b0, 8'd150});
    step(1'b1, 8'd200, 8'd100, 1'b1, "mid_rst",    9'd0);
    step(1'b0, 8'd10,  8'd3,   1'b1, "post_rst",   {1'b0, 8'd14});
    step(1'b0, 8'd240, 8'd16,  1'b0, "post_rst2",  {1'b1, 8'd0});

    // Random run against the arithmetic reference.
    for (int i = 0; i < 10000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      ref_sum = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      step(1'b0, ra, rb, rc, "random", ref_sum);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
